// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
//   Multiplexed 7-segment display driver for the board-level debug view.
//   A prescaler in the clk_i domain sets the digit-slot length. A slot index
//   walks the digits in turn. A 32-bit value is double-buffered: data_i goes
//   into a shadow register, and the shadow is copied to the display register
//   only at frame boundaries, so a frame never shows half of an old value and
//   half of a new one. Each digit shows one hex nibble.
//
// Ports
//   clk_i        in   1           system clock (only clock used)
//   rst          in   1           synchronous, active-high reset
//   data_i       in   32          value to display
//   data_we_i    in   1           capture data_i into the shadow register
//   dp_i         in   8           decimal point enable, bit i -> digit i
//   blank_i      in   8           force digit i dark when bit i = 1
//   an_o         out  NUM_DIGITS  digit anode enables, one-hot when asserted
//   seg_o        out  8           [7]=dp, [6:0]=g,f,e,d,c,b,a
//   scan_tick_o  out  1           one-cycle pulse at each digit-slot boundary
//   frame_o      out  1           one-cycle pulse when the slot index wraps to 0
//
// Write strobe: data_we_i has no handshake. A shadow write happens on every
// clock edge where data_we_i is high, so back-to-back writes keep the last one.
// A write on a frame-boundary edge lands in the shadow after the copy to the
// display register, so it shows up one frame later.
// -----------------------------------------------------------------------------
module seg7_scan #(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_CYC  = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [31:0]           data_i,
  input  logic                  data_we_i,
  input  logic [7:0]            dp_i,
  input  logic [7:0]            blank_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [7:0]            seg_o,
  output logic                  scan_tick_o,
  output logic                  frame_o
);

  localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

  // Scan state
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [31:0]           shadow;
  logic [31:0]           disp;

  // Registered outputs. These are kept active-high inside the block and are
  // inverted once at the ports.
  logic [NUM_DIGITS-1:0] an_act;
  logic [7:0]            seg_act;
  logic                  tick_q;
  logic                  frame_q;

  // Combinational helpers
  logic                  slot_end;
  logic                  frame_end;
  logic                  in_gap;
  logic                  lit;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            seg_next;

  // Segment bits are ordered {g,f,e,d,c,b,a}, with 1 meaning the segment is lit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // The anti-ghosting gap covers the first BLANK_CYC cycles of each slot.
  // When BLANK_CYC is zero there is no gap, and this avoids an always-false
  // compare.
  generate
    if (BLANK_CYC == 0) begin : g_no_gap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (cnt < CW'(BLANK_CYC));
    end
  endgenerate

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    nibble    = disp[{idx, 2'b00} +: 4];
    glyph     = hex7(nibble);
    lit       = !in_gap && !blank_i[idx];
    an_next   = '0;
    seg_next  = 8'h00;
    if (lit) begin
      an_next  = NUM_DIGITS'(1) << idx;
      seg_next = {dp_i[idx], glyph};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
      an_act  <= '0;
      seg_act <= 8'h00;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_end ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      tick_q  <= slot_end;
      frame_q <= frame_end;
      // The copy reads shadow before this edge's write, so a write on the
      // same edge is held over to the next frame.
      if (frame_end) disp <= shadow;
      if (data_we_i) shadow <= data_i;
      // These are one cycle behind the scan state they were built from.
      an_act  <= an_next;
      seg_act <= seg_next;
    end
  end

  assign an_o        = ACTIVE_LOW ? ~an_act  : an_act;
  assign seg_o       = ACTIVE_LOW ? ~seg_act : seg_act;
  assign scan_tick_o = tick_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan. Instance "a" uses SCAN_DIV=4, BLANK_CYC=1 with active-low
// outputs. Instance "b" uses SCAN_DIV=2, BLANK_CYC=0 with active-high outputs.
// Both instances share the same inputs. A reference model derives the expected
// outputs from the number of clock edges since reset.
module tb_seg7_scan;
  localparam int ND = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        data_we = 1'b0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank = '0;

  logic [7:0] an_a, seg_a, an_b, seg_b;
  logic       tick_a, frame_a, tick_b, frame_b;

  int vectors = 0;
  int miscompares = 0;

  seg7_scan #(.SCAN_DIV(4), .NUM_DIGITS(8), .BLANK_CYC(1), .ACTIVE_LOW(1'b1)) dut (
    .clk_i(clk), .rst(rst), .data_i(data), .data_we_i(data_we), .dp_i(dp),
    .blank_i(blank), .an_o(an_a), .seg_o(seg_a), .scan_tick_o(tick_a), .frame_o(frame_a)
  );

  seg7_scan #(.SCAN_DIV(2), .NUM_DIGITS(8), .BLANK_CYC(0), .ACTIVE_LOW(1'b0)) dut_b (
    .clk_i(clk), .rst(rst), .data_i(data), .data_we_i(data_we), .dp_i(dp),
    .blank_i(blank), .an_o(an_b), .seg_o(seg_b), .scan_tick_o(tick_b), .frame_o(frame_b)
  );

  // ---------------- reference model ----------------
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_sd [2] = '{4, 2};
  int          m_bl [2] = '{1, 0};
  bit          m_al [2] = '{1'b1, 1'b0};
  int          m_k  [2];   // clock edges seen since reset
  logic [31:0] m_shadow [2];
  logic [31:0] m_disp [2];
  logic [7:0]  exp_an [2];
  logic [7:0]  exp_seg [2];
  logic        exp_tick [2];
  logic        exp_frame [2];

  // Returns {an, seg} for the scan position reached after k edges.
  function automatic logic [15:0] predict(int sd, int bl, bit al, int k,
                                          logic [31:0] dsp, logic [7:0] dpv, logic [7:0] blk);
    int pos, digit;
    logic [7:0] an, seg;
    logic [3:0] nib;
    pos = k % sd;
    digit = (k / sd) % ND;
    an = 8'h00;
    seg = 8'h00;
    if (pos >= bl && blk[digit] == 1'b0) begin
      an  = 8'(1 << digit);
      nib = 4'((dsp >> (4 * digit)) & 32'hF);
      seg = {dpv[digit], hex_tbl[nib]};
    end
    if (al) begin
      an  = ~an;
      seg = ~seg;
    end
    return {an, seg};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_k[i] = 0;
        m_shadow[i] = '0;
        m_disp[i] = '0;
        exp_an[i] = m_al[i] ? 8'hFF : 8'h00;
        exp_seg[i] = m_al[i] ? 8'hFF : 8'h00;
        exp_tick[i] = 1'b0;
        exp_frame[i] = 1'b0;
      end else begin
        {exp_an[i], exp_seg[i]} = predict(m_sd[i], m_bl[i], m_al[i], m_k[i], m_disp[i], dp, blank);
        m_k[i] = m_k[i] + 1;
        exp_tick[i] = (m_k[i] % m_sd[i]) == 0;
        exp_frame[i] = (m_k[i] % (m_sd[i] * ND)) == 0;
        if (exp_frame[i]) m_disp[i] = m_shadow[i];
        if (data_we) m_shadow[i] = data;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    data = $urandom;
    data_we = 1'b1;
    dp = 8'($urandom);
    blank = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (an_a !== 8'hFF || seg_a !== 8'hFF || tick_a !== 1'b0 || frame_a !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_a: an=%h seg=%h tick=%b frame=%b, expected an=ff seg=ff tick=0 frame=0",
                 an_a, seg_a, tick_a, frame_a);
      end
      vectors++;
      if (an_b !== 8'h00 || seg_b !== 8'h00 || tick_b !== 1'b0 || frame_b !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_b: an=%h seg=%h tick=%b frame=%b, expected all 0",
                 an_b, seg_b, tick_b, frame_b);
      end
    end
    rst = 1'b0;
    data_we = 1'b0;
    dp = 8'h00;
    blank = 8'h00;
  endtask

  task automatic test_polarity();
    cycle();
    vectors++;
    if (an_b !== 8'h01 || seg_b !== 8'h3F) begin
      miscompares++;
      $display("FAIL polarity_b: an=%h seg=%h, expected an=01 seg=3f", an_b, seg_b);
    end
    vectors++;
    if (an_a !== 8'hFF || seg_a !== 8'hFF) begin
      miscompares++;
      $display("FAIL first_gap_a: an=%h seg=%h, expected an=ff seg=ff", an_a, seg_a);
    end
  endtask

  task automatic test_tick_frame();
    int ticks = 0;
    int frames = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      ticks += int'(tick_a);
      frames += int'(frame_a);
      vectors++;
      if (tick_a !== exp_tick[0] || frame_a !== exp_frame[0]) begin
        miscompares++;
        $display("FAIL tick_frame_a: tick=%b frame=%b, expected tick=%b frame=%b",
                 tick_a, frame_a, exp_tick[0], exp_frame[0]);
      end
      vectors++;
      if (tick_b !== exp_tick[1] || frame_b !== exp_frame[1]) begin
        miscompares++;
        $display("FAIL tick_frame_b: tick=%b frame=%b, expected tick=%b frame=%b",
                 tick_b, frame_b, exp_tick[1], exp_frame[1]);
      end
    end
    vectors++;
    if (ticks != 16 || frames != 2) begin
      miscompares++;
      $display("FAIL tick_count: ticks=%0d frames=%0d in 64 cycles, expected 16 and 2", ticks, frames);
    end
  endtask

  task automatic test_hex_scan();
    int n = 0;
    int gaps = 0;
    data = 32'h89ABCDEF;
    data_we = 1'b1;
    cycle();
    data_we = 1'b0;
    do begin
      cycle();
      n++;
    end while (frame_a !== 1'b1 && n < 100);
    vectors++;
    if (frame_a !== 1'b1) begin
      miscompares++;
      $display("FAIL hex_wait_frame: no frame_o within 100 cycles, expected a frame pulse");
    end
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (an_a === 8'hFF) gaps++;
      vectors++;
      if (an_a !== exp_an[0] || seg_a !== exp_seg[0]) begin
        miscompares++;
        $display("FAIL hex_scan: an=%h seg=%h, expected an=%h seg=%h", an_a, seg_a, exp_an[0], exp_seg[0]);
      end
      if (an_a === 8'hFE) begin
        vectors++;
        if (seg_a !== 8'h8E) begin
          miscompares++;
          $display("FAIL hex_digit0: seg=%h, expected 8e", seg_a);
        end
      end
      if (an_a === 8'h7F) begin
        vectors++;
        if (seg_a !== 8'h80) begin
          miscompares++;
          $display("FAIL hex_digit7: seg=%h, expected 80", seg_a);
        end
      end
    end
    vectors++;
    if (gaps != 8) begin
      miscompares++;
      $display("FAIL hex_gap_count: gap cycles=%0d, expected 8", gaps);
    end
  endtask

  task automatic test_write_on_frame();
    int n = 0;
    logic [31:0] nv;
    logic [7:0]  new_seg;
    while ((m_k[0] % 32) != 31 && n < 100) begin
      cycle();
      n++;
    end
    nv = {$urandom_range(0, 32'h0FFF_FFFF), 4'h5};
    new_seg = ~{1'b0, hex_tbl[4'h5]};
    data = nv;
    data_we = 1'b1;
    cycle();
    data_we = 1'b0;
    vectors++;
    if (frame_a !== 1'b1) begin
      miscompares++;
      $display("FAIL wof_edge: frame=%b, expected 1 on the write edge", frame_a);
    end
    for (int i = 0; i < 64; i++) begin
      cycle();
      vectors++;
      if (an_a !== exp_an[0] || seg_a !== exp_seg[0]) begin
        miscompares++;
        $display("FAIL wof_scan: an=%h seg=%h, expected an=%h seg=%h", an_a, seg_a, exp_an[0], exp_seg[0]);
      end
      if (an_a === 8'hFE) begin
        vectors++;
        if (i < 32 && seg_a !== 8'h8E) begin
          miscompares++;
          $display("FAIL wof_old_frame: seg=%h, expected 8e", seg_a);
        end else if (i >= 32 && seg_a !== new_seg) begin
          miscompares++;
          $display("FAIL wof_new_frame: seg=%h, expected %h", seg_a, new_seg);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    blank = 8'h0F;
    dp = 8'h10;
    for (int i = 0; i < 40; i++) begin
      cycle();
      vectors++;
      if ((an_a & 8'h0F) !== 8'h0F) begin
        miscompares++;
        $display("FAIL blank_low_digits: an=%h, expected low nibble f", an_a);
      end
      vectors++;
      if (an_a !== exp_an[0] || seg_a !== exp_seg[0]) begin
        miscompares++;
        $display("FAIL blank_dp_scan: an=%h seg=%h, expected an=%h seg=%h", an_a, seg_a, exp_an[0], exp_seg[0]);
      end
      if (an_a === 8'hEF) begin
        vectors++;
        if (seg_a[7] !== 1'b0) begin
          miscompares++;
          $display("FAIL dp_digit4: seg[7]=%b, expected 0", seg_a[7]);
        end
      end
    end
    blank = 8'h00;
    dp = 8'h00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      data = $urandom;
      data_we = ($urandom_range(0, 3) == 0);
      dp = 8'($urandom);
      blank = 8'($urandom) & 8'($urandom);
      cycle();
      vectors++;
      if (an_a !== exp_an[0] || seg_a !== exp_seg[0] || tick_a !== exp_tick[0] || frame_a !== exp_frame[0]) begin
        miscompares++;
        $display("FAIL random_a: an=%h seg=%h tick=%b frame=%b, expected an=%h seg=%h tick=%b frame=%b",
                 an_a, seg_a, tick_a, frame_a, exp_an[0], exp_seg[0], exp_tick[0], exp_frame[0]);
      end
      vectors++;
      if (an_b !== exp_an[1] || seg_b !== exp_seg[1] || tick_b !== exp_tick[1] || frame_b !== exp_frame[1]) begin
        miscompares++;
        $display("FAIL random_b: an=%h seg=%h tick=%b frame=%b, expected an=%h seg=%h tick=%b frame=%b",
                 an_b, seg_b, tick_b, frame_b, exp_an[1], exp_seg[1], exp_tick[1], exp_frame[1]);
      end
    end
    data_we = 1'b0;
    dp = 8'h00;
    blank = 8'h00;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(((m_k[0] / 4) % 8) == 5 && (m_k[0] % 4) == 2) && n < 100) begin
      cycle();
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL reset_mid_wait: slot 5 not reached in 100 cycles, expected it within one frame");
    end
    rst = 1'b1;
    data_we = 1'b1;
    data = $urandom;
    cycle();
    rst = 1'b0;
    data_we = 1'b0;
    vectors++;
    if (an_a !== 8'hFF || seg_a !== 8'hFF || tick_a !== 1'b0 || frame_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: an=%h seg=%h tick=%b frame=%b, expected an=ff seg=ff tick=0 frame=0",
               an_a, seg_a, tick_a, frame_a);
    end
    for (int j = 1; j <= 8; j++) begin
      cycle();
      vectors++;
      if (tick_a !== (j % 4 == 0)) begin
        miscompares++;
        $display("FAIL restart_tick: cycle %0d tick=%b, expected %b", j, tick_a, (j % 4 == 0));
      end
      if (j == 2) begin
        vectors++;
        if (an_a !== 8'hFE || seg_a !== 8'hC0) begin
          miscompares++;
          $display("FAIL restart_digit0: an=%h seg=%h, expected an=fe seg=c0", an_a, seg_a);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_polarity();
    test_tick_frame();
    test_hex_scan();
    test_write_on_frame();
    test_blank_dp();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
